// File: rtl/uart_tx_core.sv
// UART transmit engine: serializes one byte per start request into
// start / 5-8 data (LSB first) / optional parity / 1-2 stop bits.
module uart_tx_core (
  input  logic        pClk,
  input  logic        pReset,
  input  logic        TxEn,
  input  logic        TxStart,
  input  logic [7:0]  TxData,
  input  logic [11:0] UBRR,
  input  logic [1:0]  DLS,
  input  logic        STOP,
  input  logic        PEN,
  input  logic        EPS,
  output logic        Tx,
  output logic        TxDone,
  output logic        TxBusy,
  output logic        TxErr,
  output logic [2:0]  DbgState
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP1  = 3'd5,
    STOP2  = 3'd6
  } state_t;

  state_t      state;
  logic [7:0]  shiftReg;
  logic [7:0]  dataSh;
  logic [15:0] baudCnt;
  logic [2:0]  bitCnt;
  logic [11:0] ubrrSh;
  logic [1:0]  dlsSh;
  logic        stopSh;
  logic        penSh;
  logic        epsSh;

  logic [7:0]  dataMask;
  logic        parityBit;
  logic        bitEnd;
  logic [2:0]  lastBit;

  assign DbgState = state;

  // Bit period is 16*(UBRR+1) cycles, so the terminal count is {UBRR, 4'hF}.
  assign bitEnd  = (baudCnt == {ubrrSh, 4'hF});
  assign lastBit = 3'd4 + {1'b0, dlsSh};

  always_comb begin
    dataMask = 8'h1F;
    case (dlsSh)
      2'd1:    dataMask = 8'h3F;
      2'd2:    dataMask = 8'h7F;
      2'd3:    dataMask = 8'hFF;
      default: dataMask = 8'h1F;
    endcase
  end

  // Parity covers only the bits actually sent; bits above the length are masked.
  assign parityBit = epsSh ? (^(dataSh & dataMask)) : (~^(dataSh & dataMask));

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      state    <= IDLE;
      Tx       <= 1'b1;
      TxDone   <= 1'b0;
      TxBusy   <= 1'b0;
      TxErr    <= 1'b0;
      shiftReg <= 8'h00;
      dataSh   <= 8'h00;
      baudCnt  <= 16'h0000;
      bitCnt   <= 3'd0;
      ubrrSh   <= 12'h000;
      dlsSh    <= 2'd0;
      stopSh   <= 1'b0;
      penSh    <= 1'b0;
      epsSh    <= 1'b0;
    end else begin
      TxDone <= 1'b0;
      TxErr  <= TxStart && (state != IDLE);
      case (state)
        IDLE: begin
          Tx <= 1'b1;
          if (TxStart && TxEn) begin
            state  <= LOAD;
            TxBusy <= 1'b1;
          end
        end
        LOAD: begin
          shiftReg <= TxData;
          dataSh   <= TxData;
          ubrrSh   <= UBRR;
          dlsSh    <= DLS;
          stopSh   <= STOP;
          penSh    <= PEN;
          epsSh    <= EPS;
          baudCnt  <= 16'h0000;
          bitCnt   <= 3'd0;
          Tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (bitEnd) begin
            baudCnt <= 16'h0000;
            Tx      <= shiftReg[0];
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt + 16'd1;
          end
        end
        DATA: begin
          if (bitEnd) begin
            baudCnt <= 16'h0000;
            if (bitCnt == lastBit) begin
              bitCnt <= 3'd0;
              if (penSh) begin
                Tx    <= parityBit;
                state <= PARITY;
              end else begin
                Tx    <= 1'b1;
                state <= STOP1;
              end
            end else begin
              bitCnt   <= bitCnt + 3'd1;
              shiftReg <= {1'b0, shiftReg[7:1]};
              Tx       <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt + 16'd1;
          end
        end
        PARITY: begin
          if (bitEnd) begin
            baudCnt <= 16'h0000;
            Tx      <= 1'b1;
            state   <= STOP1;
          end else begin
            baudCnt <= baudCnt + 16'd1;
          end
        end
        STOP1: begin
          if (bitEnd) begin
            baudCnt <= 16'h0000;
            if (stopSh) begin
              state <= STOP2;
            end else begin
              state  <= IDLE;
              TxDone <= 1'b1;
              TxBusy <= 1'b0;
            end
          end else begin
            baudCnt <= baudCnt + 16'd1;
          end
        end
        STOP2: begin
          if (bitEnd) begin
            baudCnt <= 16'h0000;
            state   <= IDLE;
            TxDone  <= 1'b1;
            TxBusy  <= 1'b0;
          end else begin
            baudCnt <= baudCnt + 16'd1;
          end
        end
        default: begin
          state  <= IDLE;
          Tx     <= 1'b1;
          TxBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: frame-level model scoreboard checked every cycle,
// plus directed frames with hand-computed bit sequences and done timing.
module tb_uart_tx_core;

  logic        pClk;
  logic        pReset;
  logic        TxEn;
  logic        TxStart;
  logic [7:0]  TxData;
  logic [11:0] UBRR;
  logic [1:0]  DLS;
  logic        STOP;
  logic        PEN;
  logic        EPS;
  logic        Tx;
  logic        TxDone;
  logic        TxBusy;
  logic        TxErr;
  logic [2:0]  DbgState;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  uart_tx_core dut (
    .pClk     (pClk),
    .pReset   (pReset),
    .TxEn     (TxEn),
    .TxStart  (TxStart),
    .TxData   (TxData),
    .UBRR     (UBRR),
    .DLS      (DLS),
    .STOP     (STOP),
    .PEN      (PEN),
    .EPS      (EPS),
    .Tx       (Tx),
    .TxDone   (TxDone),
    .TxBusy   (TxBusy),
    .TxErr    (TxErr),
    .DbgState (DbgState)
  );

  // ---------------- clock / reset ----------------
  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  always @(posedge pClk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t, required < 1000000", $time);
    $fatal(1, "timeout");
  end

  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- scoreboard / model ----------------
  // Each entry is the expected {Tx, TxBusy, TxDone} for one clock cycle.
  logic [2:0] exp_q[$];
  logic       exp_err;
  bit         pend_load;
  logic [2:0] cur_exp;

  // Builds the whole frame from the frame rules using the inputs present
  // during the load cycle.
  function automatic void build_frame();
    logic       bits[$];
    logic [7:0] d;
    int nd, ones, n;
    d    = TxData;
    nd   = 5 + int'(DLS);
    n    = 16 * (int'(UBRR) + 1);
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (PEN) bits.push_back(EPS ? logic'(ones % 2) : logic'(1 - (ones % 2)));
    for (int s = 0; s <= int'(STOP); s++) bits.push_back(1'b1);
    foreach (bits[k])
      for (int c = 0; c < n; c++) exp_q.push_back({bits[k], 1'b1, 1'b0});
    exp_q.push_back(3'b101);
  endfunction

  always @(negedge pClk) begin
    if (!pReset) begin
      exp_q.delete();
      exp_err   = 1'b0;
      pend_load = 1'b0;
      cur_exp   = 3'b100;
    end else begin
      cur_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b100;
    end
    check("cycle_outputs", int'({Tx, TxBusy, TxDone, TxErr}), int'({cur_exp, exp_err}));
    if (pReset) begin
      if (pend_load) begin
        build_frame();
        pend_load = 1'b0;
      end
      exp_err = TxStart && cur_exp[1];
      if (TxStart && TxEn && !cur_exp[1]) begin
        exp_q.push_back(3'b110);
        pend_load = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Starts a frame from posedge+1, checks each bit at mid-period against
  // seq[i] (bit i in time order) and the edge after E1 at which TxDone rises.
  // Returns inside the TxDone cycle.
  task automatic send_frame(input logic [7:0] data, input logic [1:0] dls,
                            input logic stp, input logic pen, input logic eps,
                            input logic [11:0] ubrr, input int nbits,
                            input logic [15:0] seq, input int done_edge,
                            input string name, output int e1_cyc, output int done_cyc);
    int n, elapsed, target;
    bit seen;
    TxData  = data;
    DLS     = dls;
    STOP    = stp;
    PEN     = pen;
    EPS     = eps;
    UBRR    = ubrr;
    TxStart = 1'b1;
    @(posedge pClk); #1;
    TxStart = 1'b0;
    @(posedge pClk); #1;
    e1_cyc  = cyc;
    n       = 16 * (int'(ubrr) + 1);
    elapsed = 0;
    for (int i = 0; i < nbits; i++) begin
      target = i * n + n / 2;
      repeat (target - elapsed) @(posedge pClk);
      elapsed = target;
      #1;
      check({name, "_bit"}, int'(Tx), int'(seq[i]));
    end
    seen = 1'b0;
    while (!seen && elapsed < done_edge + 64) begin
      @(posedge pClk);
      elapsed++;
      #1;
      if (TxDone) seen = 1'b1;
    end
    check({name, "_done_edge"}, seen ? elapsed : -1, done_edge);
    done_cyc = cyc;
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) @(posedge pClk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e1a, da, e1b, db, dones;
    pReset  = 1'b0;
    TxEn    = 1'b1;
    TxStart = 1'b0;
    TxData  = 8'h00;
    UBRR    = 12'h000;
    DLS     = 2'd3;
    STOP    = 1'b0;
    PEN     = 1'b0;
    EPS     = 1'b0;
    repeat (3) @(posedge pClk);
    #1;
    check("reset_tx", int'(Tx), 1);
    check("reset_busy", int'(TxBusy), 0);
    check("reset_done", int'(TxDone), 0);
    check("reset_err", int'(TxErr), 0);
    pReset = 1'b1;
    idle_cycles(4);

    // 8N1 0xA5 then 0x3C started in the TxDone cycle
    send_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 12'h000, 10, {6'd0, 1'b1, 8'hA5, 1'b0},
               160, "f8n1_a5", e1a, da);
    send_frame(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 12'h000, 10, {6'd0, 1'b1, 8'h3C, 1'b0},
               160, "b2b_3c", e1b, db);
    check("b2b_gap", e1b - da, 2);
    idle_cycles(5);

    // 7E2, N=32: data 1010011, parity 0, two stop bits
    send_frame(8'h53, 2'd2, 1'b1, 1'b1, 1'b1, 12'h001, 11, {5'd0, 2'b11, 1'b0, 7'h53, 1'b0},
               352, "f7e2_53", e1a, da);
    idle_cycles(5);

    // 5O1: only five ones sent, odd parity bit is 0
    send_frame(8'hFF, 2'd0, 1'b0, 1'b1, 1'b0, 12'h000, 8, {8'd0, 1'b1, 1'b0, 5'h1F, 1'b0},
               128, "f5o1_ff", e1a, da);
    idle_cycles(5);

    // Start while busy, then enable and config changed mid-frame
    fork
      send_frame(8'h96, 2'd3, 1'b0, 1'b0, 1'b0, 12'h000, 10, {6'd0, 1'b1, 8'h96, 1'b0},
                 160, "busy_96", e1a, da);
      begin
        repeat (40) @(posedge pClk);
        #1;
        TxStart = 1'b1;
        @(posedge pClk); #1;
        TxStart = 1'b0;
        check("err_pulse", int'(TxErr), 1);
        @(posedge pClk); #1;
        check("err_width", int'(TxErr), 0);
        TxEn = 1'b0;
        UBRR = 12'h003;
        DLS  = 2'd0;
        PEN  = 1'b1;
        STOP = 1'b1;
      end
    join
    idle_cycles(3);

    // TxStart with the transmitter disabled is ignored silently
    TxStart = 1'b1;
    @(posedge pClk); #1;
    TxStart = 1'b0;
    @(posedge pClk); #1;
    check("dis_busy", int'(TxBusy), 0);
    check("dis_err", int'(TxErr), 0);
    idle_cycles(20);
    check("dis_tx", int'(Tx), 1);
    TxEn = 1'b1;

    // Reset in the middle of the data bits
    UBRR    = 12'h000;
    DLS     = 2'd3;
    STOP    = 1'b0;
    PEN     = 1'b0;
    TxData  = 8'hC3;
    TxStart = 1'b1;
    @(posedge pClk); #1;
    TxStart = 1'b0;
    repeat (50) @(posedge pClk);
    #3;
    pReset = 1'b0;
    #1;
    check("rst_mid_tx", int'(Tx), 1);
    check("rst_mid_busy", int'(TxBusy), 0);
    repeat (3) @(posedge pClk);
    #1;
    check("rst_mid_done", int'(TxDone), 0);
    pReset = 1'b1;
    dones = 0;
    repeat (200) begin
      @(posedge pClk); #1;
      if (TxDone) dones++;
    end
    check("rst_no_done", dones, 0);

    send_frame(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 12'h000, 10, {6'd0, 1'b1, 8'h5A, 1'b0},
               160, "post_rst_5a", e1a, da);
    idle_cycles(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
